// File: rtl/rgb2gray_frontend_if.sv
// Video bus between the capture side and rgb2gray_frontend: RGB888 timing in, gray timing out.
// The master drives the pre_* side; the frontend (slave) drives the post_* side.
`timescale 1ns/1ps
interface rgb2gray_frontend_if;
   logic        pre_vs;
   logic        pre_de;
   logic [23:0] pre_rgb;
   logic        post_vs;
   logic        post_de;
   logic [7:0]  post_data;

   modport master (
      output pre_vs, pre_de, pre_rgb,
      input  post_vs, post_de, post_data
   );

   modport slave (
      input  pre_vs, pre_de, pre_rgb,
      output post_vs, post_de, post_data
   );
endinterface

// File: rtl/rgb2gray_frontend.sv
// RGB888 to 8-bit gray front end: 3-stage luma/channel pipe, frame counter, sticky geometry checks.
// Define GRAY_STATS_EN to add the per-frame luma accumulator driving luma_sum.
`timescale 1ns/1ps
module rgb2gray_frontend #(
   parameter int IMG_HDISP = 1280,
   parameter int IMG_VDISP = 720
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         ch_sel,
   input  logic               err_clr,
   rgb2gray_frontend_if.slave vid,
   output logic [1:0]         mode_act,
   output logic [15:0]        frame_cnt,
   output logic               line_err,
   output logic               frame_err,
   output logic [31:0]        luma_sum
);

   localparam int PIX_CLOG  = $clog2(IMG_HDISP + 1);
   localparam int LINE_CLOG = $clog2(IMG_VDISP + 1);
   localparam int PIX_W     = (PIX_CLOG > 13) ? PIX_CLOG : 13;
   localparam int LINE_W    = (LINE_CLOG > 12) ? LINE_CLOG : 12;

   localparam logic [PIX_W-1:0]  PIX_MAX = '1;
   localparam logic [PIX_W-1:0]  HDISP_V = PIX_W'(IMG_HDISP);
   localparam logic [LINE_W-1:0] VDISP_V = LINE_W'(IMG_VDISP);

   logic              vs_q;
   logic              de_q;
   logic              armed;
   logic              frame_start;
   logic              de_fall;
   logic              line_set;
   logic              frame_set;
   logic [PIX_W-1:0]  pix_cnt;
   logic [LINE_W-1:0] line_cnt;

   logic [14:0]       r_d1;
   logic [15:0]       g_d1;
   logic [12:0]       b_d1;
   logic [7:0]        ch_sel_px;
   logic [7:0]        ch_d1;
   logic [7:0]        ch_d2;
   logic              luma_d1;
   logic              luma_d2;
   logic              vs_d1;
   logic              vs_d2;
   logic              de_d1;
   logic              de_d2;
   logic [15:0]       sum_d2;
   logic [16:0]       rounded;
   logic [7:0]        y;

   assign frame_start = vid.pre_vs & ~vs_q;
   assign de_fall     = de_q & ~vid.pre_de;
   assign line_set    = de_fall & armed & (pix_cnt != HDISP_V);
   assign frame_set   = frame_start & armed & (line_cnt != VDISP_V);

   // Frame-start bookkeeping: mode is latched once per frame so a mid-frame ch_sel change waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q      <= 1'b0;
         de_q      <= 1'b0;
         armed     <= 1'b0;
         mode_act  <= 2'd0;
         frame_cnt <= 16'd0;
      end else begin
         vs_q <= vid.pre_vs;
         de_q <= vid.pre_de;
         if (frame_start) begin
            mode_act  <= ch_sel;
            frame_cnt <= frame_cnt + 16'd1;
            armed     <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt  <= '0;
         line_cnt <= '0;
      end else begin
         if (de_fall) begin
            pix_cnt <= '0;
         end else if (vid.pre_de && (pix_cnt != PIX_MAX)) begin
            pix_cnt <= pix_cnt + 1'b1;
         end
         if (frame_start) begin
            line_cnt <= '0;
         end else if (de_fall) begin
            line_cnt <= line_cnt + 1'b1;
         end
      end
   end

   // A set condition outranks a coincident clear so no error is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_err  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (line_set) begin
            line_err <= 1'b1;
         end else if (err_clr) begin
            line_err <= 1'b0;
         end
         if (frame_set) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end
      end
   end

   always_comb begin
      ch_sel_px = vid.pre_rgb[23:16];
      case (mode_act)
         2'd2:    ch_sel_px = vid.pre_rgb[15:8];
         2'd3:    ch_sel_px = vid.pre_rgb[7:0];
         default: ch_sel_px = vid.pre_rgb[23:16];
      endcase
   end

   // Pass-through channels ride the same stages as luma so latency never depends on mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1    <= 15'd0;
         g_d1    <= 16'd0;
         b_d1    <= 13'd0;
         ch_d1   <= 8'd0;
         luma_d1 <= 1'b0;
         vs_d1   <= 1'b0;
         de_d1   <= 1'b0;
         sum_d2  <= 16'd0;
         ch_d2   <= 8'd0;
         luma_d2 <= 1'b0;
         vs_d2   <= 1'b0;
         de_d2   <= 1'b0;
      end else begin
         r_d1    <= {7'd0, vid.pre_rgb[23:16]} * 15'd77;
         g_d1    <= {8'd0, vid.pre_rgb[15:8]} * 16'd150;
         b_d1    <= {5'd0, vid.pre_rgb[7:0]} * 13'd29;
         ch_d1   <= ch_sel_px;
         luma_d1 <= (mode_act == 2'd0);
         vs_d1   <= vid.pre_vs;
         de_d1   <= vid.pre_de;
         sum_d2  <= {1'b0, r_d1} + g_d1 + {3'b000, b_d1};
         ch_d2   <= ch_d1;
         luma_d2 <= luma_d1;
         vs_d2   <= vs_d1;
         de_d2   <= de_d1;
      end
   end

   always_comb begin
      rounded = {1'b0, sum_d2} + 17'd128;
      y       = (rounded[16:8] > 9'd255) ? 8'd255 : rounded[15:8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid.post_vs   <= 1'b0;
         vid.post_de   <= 1'b0;
         vid.post_data <= 8'd0;
      end else begin
         vid.post_vs   <= vs_d2;
         vid.post_de   <= de_d2;
         vid.post_data <= de_d2 ? (luma_d2 ? y : ch_d2) : 8'd0;
      end
   end

`ifdef GRAY_STATS_EN
   logic [7:0]  y_d3;
   logic [31:0] acc;
   logic        post_vs_q;

   // Latching on the output-side vs edge guarantees every pixel of the previous frame is included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_d3      <= 8'd0;
         acc       <= 32'd0;
         post_vs_q <= 1'b0;
         luma_sum  <= 32'd0;
      end else begin
         y_d3      <= y;
         post_vs_q <= vid.post_vs;
         if (vid.post_vs && !post_vs_q) begin
            luma_sum <= acc;
            acc      <= vid.post_de ? {24'd0, y_d3} : 32'd0;
         end else if (vid.post_de) begin
            acc <= acc + {24'd0, y_d3};
         end
      end
   end
`else
   assign luma_sum = 32'd0;
`endif

endmodule

// File: tb/tb_rgb2gray_frontend.sv
// Self-checking bench for rgb2gray_frontend: directed literal checks plus randomized frames
// compared every cycle against a behavioural model of the gray stream, counters and flags.
`timescale 1ns/1ps
module tb_rgb2gray_frontend;
   localparam int TB_H = 6;
   localparam int TB_V = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  ch_sel;
   logic        err_clr;
   logic [1:0]  mode_act;
   logic [15:0] frame_cnt;
   logic        line_err;
   logic        frame_err;
   logic [31:0] luma_sum;

   int tests_run    = 0;
   int tests_failed = 0;

   int          cfg_short_line   = -1;
   int          cfg_mid_sel      = -1;
   int          cfg_probe_exp    = -1;
   bit          cfg_clr_on_short = 1'b0;
   bit          cfg_fixed        = 1'b0;
   logic [23:0] cfg_rgb          = 24'd0;
   logic [23:0] cfg_probe_rgb    = 24'd0;
   bit          clr_rand_en      = 1'b0;
   bit          err_clr_next     = 1'b0;

   rgb2gray_frontend_if vid();

   rgb2gray_frontend #(.IMG_HDISP(TB_H), .IMG_VDISP(TB_V)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ch_sel    (ch_sel),
      .err_clr   (err_clr),
      .vid       (vid),
      .mode_act  (mode_act),
      .frame_cnt (frame_cnt),
      .line_err  (line_err),
      .frame_err (frame_err),
      .luma_sum  (luma_sum)
   );

   always #5 clk = ~clk;

   // Reference model: spec rules in plain integer arithmetic, updated at each rising edge.
   int     m_mode = 0, m_frame_cnt = 0, m_pix = 0, m_lines = 0;
   bit     m_armed = 0, m_line_err = 0, m_frame_err = 0, m_prev_vs = 0, m_prev_de = 0;
   bit     pv[3], pd[3];
   int     pdata[3], py[3];
   longint m_acc = 0, m_luma_sum = 0;
   bit     m_post_vs_prev = 0;

   function automatic int ref_luma(input logic [23:0] rgb);
      int s;
      s = 77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]);
      s = (s + 128) / 256;
      return (s > 255) ? 255 : s;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_frame_cnt = 0; m_pix = 0; m_lines = 0;
      m_armed = 0; m_line_err = 0; m_frame_err = 0; m_prev_vs = 0; m_prev_de = 0;
      for (int i = 0; i < 3; i++) begin
         pv[i] = 0; pd[i] = 0; pdata[i] = 0; py[i] = 0;
      end
      m_acc = 0; m_luma_sum = 0; m_post_vs_prev = 0;
   endtask

   task automatic model_step();
      bit          vs, de, fs, df, set_l, set_f;
      logic [23:0] rgb;
      int          val;
      vs  = vid.pre_vs;
      de  = vid.pre_de;
      rgb = vid.pre_rgb;
      if (pv[2] && !m_post_vs_prev) begin
         m_luma_sum = m_acc;
         m_acc      = pd[2] ? py[2] : 0;
      end else if (pd[2]) begin
         m_acc = m_acc + py[2];
      end
      m_post_vs_prev = pv[2];
      case (m_mode)
         1:       val = int'(rgb[23:16]);
         2:       val = int'(rgb[15:8]);
         3:       val = int'(rgb[7:0]);
         default: val = ref_luma(rgb);
      endcase
      if (!de) val = 0;
      for (int i = 2; i > 0; i--) begin
         pv[i] = pv[i-1]; pd[i] = pd[i-1]; pdata[i] = pdata[i-1]; py[i] = py[i-1];
      end
      pv[0] = vs; pd[0] = de; pdata[0] = val; py[0] = ref_luma(rgb);
      fs    = vs && !m_prev_vs;
      df    = m_prev_de && !de;
      set_l = df && m_armed && (m_pix != TB_H);
      set_f = fs && m_armed && (m_lines != TB_V);
      if (df) begin
         m_lines = m_lines + 1;
         m_pix   = 0;
      end else if (de && m_pix < 8191) begin
         m_pix = m_pix + 1;
      end
      if (fs) begin
         m_lines     = 0;
         m_frame_cnt = (m_frame_cnt + 1) % 65536;
         m_mode      = int'(ch_sel);
         m_armed     = 1;
      end
      m_line_err  = set_l ? 1'b1 : (err_clr ? 1'b0 : m_line_err);
      m_frame_err = set_f ? 1'b1 : (err_clr ? 1'b0 : m_frame_err);
      m_prev_vs   = vs;
      m_prev_de   = de;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Every-cycle comparison of all outputs against the model, sampled on the falling edge.
   initial begin
      logic [61:0] got, exp;
      logic [31:0] exp_sum;
      forever begin
         @(negedge clk);
`ifdef GRAY_STATS_EN
         exp_sum = 32'(m_luma_sum);
`else
         exp_sum = 32'd0;
`endif
         got = {vid.post_vs, vid.post_de, vid.post_data, mode_act, frame_cnt, line_err, frame_err, luma_sum};
         exp = {pv[2], pd[2], 8'(pdata[2]), 2'(m_mode), 16'(m_frame_cnt), m_line_err, m_frame_err, exp_sum};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL cycle_compare t=%0t got {vs,de,data,mode,fcnt,lerr,ferr,sum}=%h required %h",
                     $time, got, exp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit vs, input bit de, input logic [23:0] rgb);
      vid.pre_vs  = vs;
      vid.pre_de  = de;
      vid.pre_rgb = rgb;
      err_clr     = err_clr_next || (clr_rand_en && ($urandom_range(0, 19) == 0));
      err_clr_next = 1'b0;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
   endtask

   task automatic send_frame(input int nlines, input int npix);
      applyStimulus(1, 0, 24'd0);
      applyStimulus(1, 0, 24'd0);
      applyStimulus(0, 0, 24'd0);
      applyStimulus(0, 0, 24'd0);
      for (int l = 0; l < nlines; l++) begin
         int n;
         n = (l == cfg_short_line) ? npix - 1 : npix;
         if (l == 1 && cfg_mid_sel >= 0) ch_sel = 2'(cfg_mid_sel);
         for (int p = 0; p < n; p++) begin
            logic [23:0] px;
            px = cfg_fixed ? cfg_rgb : 24'($urandom);
            if (l == 0 && p == 0 && cfg_probe_exp >= 0) px = cfg_probe_rgb;
            applyStimulus(0, 1, px);
            if (l == 0 && cfg_probe_exp >= 0 && p == 1)
               checkOutput("probe_not_early", 32'(vid.post_de), 0);
            if (l == 0 && cfg_probe_exp >= 0 && p == 2) begin
               checkOutput("probe_de", 32'(vid.post_de), 1);
               checkOutput("probe_data", 32'(vid.post_data), 32'(cfg_probe_exp));
            end
         end
         if (l == cfg_short_line && cfg_clr_on_short) err_clr_next = 1'b1;
         applyStimulus(0, 0, 24'd0);
         applyStimulus(0, 0, 24'd0);
         applyStimulus(0, 0, 24'd0);
      end
   endtask

   initial begin
      int exp_mode [4];
      exp_mode[0] = 82; exp_mode[1] = 100; exp_mode[2] = 50; exp_mode[3] = 200;
      rst_n = 1'b0; ch_sel = 2'd0; err_clr = 1'b0;
      vid.pre_vs = 1'b0; vid.pre_de = 1'b0; vid.pre_rgb = 24'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_post_data", 32'(vid.post_data), 0);
      checkOutput("reset_frame_cnt", 32'(frame_cnt), 0);
      checkOutput("reset_mode_act", 32'(mode_act), 0);
      checkOutput("reset_errs", 32'({line_err, frame_err}), 0);
      checkOutput("reset_luma_sum", luma_sum, 0);
      rst_n = 1'b1;
      applyStimulus(0, 0, 24'd0);

      // White frame in luma mode
      cfg_fixed = 1; cfg_rgb = 24'hFFFFFF; cfg_probe_rgb = 24'hFFFFFF; cfg_probe_exp = 255;
      send_frame(TB_V, TB_H);
      checkOutput("white_frame_cnt", 32'(frame_cnt), 1);
      checkOutput("white_line_err", 32'(line_err), 0);
      cfg_fixed = 0;

      // Single known pixel through each mode
      cfg_probe_rgb = {8'd100, 8'd50, 8'd200};
      for (int m = 0; m < 4; m++) begin
         ch_sel = 2'(m);
         cfg_probe_exp = exp_mode[m];
         send_frame(TB_V, TB_H);
         checkOutput("mode_act_follow", 32'(mode_act), 32'(m));
      end
      checkOutput("modes_frame_cnt", 32'(frame_cnt), 5);
      checkOutput("modes_errs", 32'({line_err, frame_err}), 0);

      // Mid-frame ch_sel change waits for the next frame start
      ch_sel = 2'd0; cfg_mid_sel = 2; cfg_probe_exp = 82;
      send_frame(TB_V, TB_H);
      checkOutput("midsel_mode_held", 32'(mode_act), 0);
      cfg_mid_sel = -1; cfg_probe_exp = 50;
      send_frame(TB_V, TB_H);
      checkOutput("midsel_mode_next", 32'(mode_act), 2);
      cfg_probe_exp = -1;

      // Short line, clear, and clear colliding with a set
      cfg_short_line = 1;
      send_frame(TB_V, TB_H);
      checkOutput("short_line_err", 32'(line_err), 1);
      err_clr_next = 1'b1;
      applyStimulus(0, 0, 24'd0);
      checkOutput("line_err_cleared", 32'(line_err), 0);
      cfg_clr_on_short = 1;
      send_frame(TB_V, TB_H);
      checkOutput("set_beats_clr", 32'(line_err), 1);
      cfg_clr_on_short = 0; cfg_short_line = -1;
      err_clr_next = 1'b1;
      applyStimulus(0, 0, 24'd0);

      // Short frame flagged at the following frame start
      send_frame(TB_V - 1, TB_H);
      checkOutput("short_frame_pending", 32'(frame_err), 0);
      send_frame(TB_V, TB_H);
      checkOutput("short_frame_err", 32'(frame_err), 1);
      err_clr_next = 1'b1;
      applyStimulus(0, 0, 24'd0);
      checkOutput("frame_err_cleared", 32'(frame_err), 0);

      // Reset in mid-frame, then a partial frame: nothing flagged until armed
      applyStimulus(1, 0, 24'd0);
      applyStimulus(0, 0, 24'd0);
      for (int l = 0; l < 2; l++) begin
         for (int p = 0; p < TB_H; p++) applyStimulus(0, 1, 24'($urandom));
         applyStimulus(0, 0, 24'd0);
      end
      rst_n = 1'b0;
      applyStimulus(0, 0, 24'd0);
      applyStimulus(0, 0, 24'd0);
      rst_n = 1'b1;
      for (int l = 0; l < 2; l++) begin
         for (int p = 0; p < 3; p++) applyStimulus(0, 1, 24'($urandom));
         applyStimulus(0, 0, 24'd0);
      end
      checkOutput("partial_no_line_err", 32'(line_err), 0);
      checkOutput("partial_frame_cnt", 32'(frame_cnt), 0);
      send_frame(TB_V, TB_H);
      checkOutput("rearm_no_frame_err", 32'(frame_err), 0);
      checkOutput("rearm_frame_cnt", 32'(frame_cnt), 1);

      // Luma statistics over a flat frame of luma 10
      cfg_fixed = 1; cfg_rgb = 24'h0A0A0A;
      send_frame(TB_V, TB_H);
      cfg_fixed = 0;
      send_frame(TB_V, TB_H);
`ifdef GRAY_STATS_EN
      checkOutput("luma_sum_flat", luma_sum, 32'(TB_H * TB_V * 10));
`else
      checkOutput("luma_sum_tied", luma_sum, 0);
`endif

      // Randomized frames: geometry, modes and clears all vary
      clr_rand_en = 1'b1;
      for (int f = 0; f < 40; f++) begin
         int nl, np;
         ch_sel = 2'($urandom_range(0, 3));
         nl = TB_V;
         if ($urandom_range(0, 5) == 0) nl = ($urandom_range(0, 1) == 1) ? TB_V + 1 : TB_V - 1;
         np = ($urandom_range(0, 9) == 0) ? TB_H + 1 : TB_H;
         cfg_short_line = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
         cfg_mid_sel    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         send_frame(nl, np);
      end
      clr_rand_en = 1'b0;
      cfg_short_line = -1; cfg_mid_sel = -1;
      applyStimulus(1, 0, 24'd0);
      repeat (5) applyStimulus(0, 0, 24'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/rgb2gray_frontend.md
Name: rgb2gray_frontend

Overview:
- Input stage of the sketch pipeline. Converts RGB888 camera/HDMI video to the 8-bit gray stream that the sketch filter consumes.
- Adds a frame-synchronous channel-select mode, a frame counter and sticky geometry-error checking against the configured resolution.
- Output timing (vs/de) is a pure 3-clock delay of the input timing, so downstream line buffers see unchanged geometry.

Parameters:
IMG_HDISP, 1280, expected active pixels per line
IMG_VDISP, 720, expected active lines per frame

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
ch_sel  input  2  requested output mode: 0 luma, 1 R, 2 G, 3 B; sampled at frame start only
err_clr  input  1  one-clock pulse clearing the sticky error flags
pre_vs  input  1  input vertical sync, active high
pre_de  input  1  input data enable
pre_rgb  input  24  {R[23:16], G[15:8], B[7:0]}
post_vs  output  1  pre_vs delayed 3 clk
post_de  output  1  pre_de delayed 3 clk
post_data  output  8  gray pixel; 0 when post_de low
mode_act  output  2  ch_sel value in effect for the current frame
frame_cnt  output  16  count of frame starts, wraps at 65535->0
line_err  output  1  sticky: a line had pixel count != IMG_HDISP
frame_err  output  1  sticky: a frame had line count != IMG_VDISP
luma_sum  output  32  per-frame luma sum (optional feature)

Behaviour:
- Reset: all outputs 0; delay pipes 0; armed=0; mode_act=0 (luma).
- Frame start is the rising edge of pre_vs, detected against a registered copy of pre_vs.
  - At frame start: mode_act<=ch_sel; frame_cnt<=frame_cnt+1; armed<=1.
  - If armed was already 1, the line count is compared with IMG_VDISP; a mismatch sets frame_err. The line counter is then cleared.
- Luma arithmetic, pipelined:
  - S1: register 77*R, 150*G, 29*B (15/16/13 bit).
  - S2: register the 16-bit sum (max 65280, no overflow).
  - S3: y = (sum+128)>>8, saturated to 255 (sum 65280 -> 255).
- Channel modes 1/2/3 pass the selected channel through the same 3-stage delay, so latency is identical in all modes.
- post_data is registered at S3: y or the selected channel if de_d3=1, else 0.
- Latency: pixel at pre_rgb in cycle n appears on post_data at n+3, aligned with post_de.
- Pixel counter:
  - Increments on each pre_de=1 cycle and saturates at 2^13-1.
  - On pre_de falling edge: if armed and count != IMG_HDISP, set line_err. Line counter +1. Pixel counter cleared.
- Checks are suppressed until armed=1. A reset in mid-frame therefore never flags the partial frame.
- err_clr clears both flags. If err_clr and a set condition occur in the same cycle, set wins.
- A ch_sel change mid-frame has no effect until the next frame start.
- Counter widths: pixel 13 bit, line 12 bit (sized for the defaults; an implementation may use $clog2 of parameter+1, min these).

Optional Feature:
- Macro GRAY_STATS_EN.
- When defined:
  - A 32-bit accumulator adds the S3 y value on every de_d3 cycle, regardless of mode.
  - At each frame start, luma_sum<=accumulator and accumulator<=0. Frame start here is the post_vs rising edge, so all pixels of the previous frame are included.
  - luma_sum resets to 0.
- When not defined: no accumulator is synthesised and luma_sum is tied to 0.

Test Plan:
- Pure-white frame (R=G=B=255), mode 0, 1280x720 -> every post_data=255, first valid pixel exactly 3 clk after first pre_de, line_err=frame_err=0, frame_cnt=1 after first vs.
- Single pixel R=100,G=50,B=200 in mode 0 -> sum=7700+7500+5800=21000, post_data=(21128>>8)=82. Same pixel with modes 1/2/3 -> 100/50/200.
- ch_sel changed 0->2 mid-frame -> mode_act and output stay luma until the next pre_vs rising edge, then switch to G.
- Line of 1279 pixels -> line_err=1 after that line's de fall. err_clr pulse -> 0. err_clr coincident with another short line -> stays 1.
- Frame of 719 lines followed by vs -> frame_err=1. Reset asserted mid-frame, then a short partial frame -> no error until after the first full vs.
- GRAY_STATS_EN defined, 2x2 frame (params 2,2) of luma 10 -> luma_sum=40 after the next frame start. Undefined -> luma_sum always 0.
